// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The parity helper is only referenced when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVS_DEFAULT      = 16;
  localparam int DATA_W_DEFAULT   = 8;
  localparam int FRAME_BITS_NOPAR = 10;
  localparam int FRAME_BITS_PAR   = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Even parity of the data word, inverted for odd parity.
  function automatic logic parity_bit(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; a write is judged against the current (pre-pop) occupancy.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              wr_ok_s;
  logic              rd_ok_s;

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign wr_ok_s = wr_en && !full;
  assign rd_ok_s = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Next occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_next = count_r + CW'(1);
      2'b01:   count_next = count_r - CW'(1);
      default: count_next = count_r;
    endcase
  end

  // Pointers and occupancy; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with TX FIFO, baud/oversample timing and frame FSM.
// Define UART_TX_PARITY_EN to add the par_odd input and a parity bit (11-bit frames).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int OVS        = OVS_DEFAULT
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [DATA_W-1:0]             baud_val,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          wr_en,
`ifdef UART_TX_PARITY_EN
  input  logic                          par_odd,
`endif
  output logic                          tx,
  output logic                          tf_TXRDY,
  output logic                          tx_busy,
  output logic                          tx_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(OVS);
  localparam int IW = $clog2(DATA_W);

  tx_state_t         state_r, state_nx;
  logic [DATA_W-1:0] baud_cnt_r, baud_cnt_nx;
  logic [DATA_W-1:0] baud_lat_r, baud_lat_nx;
  logic [TW-1:0]     tick_cnt_r, tick_cnt_nx;
  logic [IW-1:0]     bit_idx_r, bit_idx_nx;
  logic [DATA_W-1:0] shift_r, shift_nx;
  logic              tx_r, tx_nx;
  logic              txrdy_r, busy_r, ovf_r;
  logic              tick_s, bit_done_s, load_s;
  logic [DATA_W-1:0] fifo_rd_data_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CW-1:0]     fifo_cnt_s, fifo_cnt_nx;
`ifdef UART_TX_PARITY_EN
  logic              par_bit_r, par_bit_nx;
`endif

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (pclk),
    .rst       (presetn),
    .wr_en     (wr_en),
    .wr_data   (data_in),
    .rd_en     (load_s),
    .rd_data   (fifo_rd_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_cnt_s),
    .count_next(fifo_cnt_nx)
  );

  // Baud timing, next state, shift register and the next tx level.
  always_comb begin
    state_nx    = state_r;
    baud_cnt_nx = baud_cnt_r;
    baud_lat_nx = baud_lat_r;
    tick_cnt_nx = tick_cnt_r;
    bit_idx_nx  = bit_idx_r;
    shift_nx    = shift_r;
    load_s      = 1'b0;
    tx_nx       = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_bit_nx  = par_bit_r;
`endif
    tick_s      = (baud_cnt_r == baud_lat_r);
    bit_done_s  = tick_s && (tick_cnt_r == TW'(OVS - 1));

    if (state_r == IDLE) begin
      baud_cnt_nx = {DATA_W{1'b0}};
      tick_cnt_nx = {TW{1'b0}};
    end else if (tick_s) begin
      baud_cnt_nx = {DATA_W{1'b0}};
      tick_cnt_nx = bit_done_s ? {TW{1'b0}} : tick_cnt_r + TW'(1);
    end else begin
      baud_cnt_nx = baud_cnt_r + DATA_W'(1);
    end

    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          load_s   = 1'b1;
          state_nx = START;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_nx   = DATA;
          bit_idx_nx = {IW{1'b0}};
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          shift_nx = shift_r >> 1;
          if (bit_idx_r == IW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_idx_nx = bit_idx_r + IW'(1);
          end
        end else begin
          state_nx = DATA;
        end
      end
      PARITY: begin
        if (bit_done_s) state_nx = STOP;
        else            state_nx = PARITY;
      end
      STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (bit_done_s) begin
          if (!fifo_empty_s) begin
            load_s   = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = STOP;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load_s) begin
      shift_nx    = fifo_rd_data_s;
      baud_lat_nx = baud_val;
      baud_cnt_nx = {DATA_W{1'b0}};
      tick_cnt_nx = {TW{1'b0}};
`ifdef UART_TX_PARITY_EN
      par_bit_nx  = parity_bit(32'(fifo_rd_data_s), par_odd);
`endif
    end else begin
      shift_nx = shift_nx;
    end

    case (state_nx)
      IDLE:    tx_nx = 1'b1;
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nx = par_bit_nx;
`endif
      STOP:    tx_nx = 1'b1;
      default: tx_nx = 1'b1;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      state_r    <= IDLE;
      baud_cnt_r <= {DATA_W{1'b0}};
      baud_lat_r <= {DATA_W{1'b0}};
      tick_cnt_r <= {TW{1'b0}};
      bit_idx_r  <= {IW{1'b0}};
      shift_r    <= {DATA_W{1'b0}};
      tx_r       <= 1'b1;
      txrdy_r    <= 1'b1;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit_r  <= 1'b0;
`endif
    end else begin
      state_r    <= state_nx;
      baud_cnt_r <= baud_cnt_nx;
      baud_lat_r <= baud_lat_nx;
      tick_cnt_r <= tick_cnt_nx;
      bit_idx_r  <= bit_idx_nx;
      shift_r    <= shift_nx;
      tx_r       <= tx_nx;
      txrdy_r    <= (fifo_cnt_nx < CW'(FIFO_DEPTH));
      busy_r     <= (state_nx != IDLE) || (fifo_cnt_nx != {CW{1'b0}});
      ovf_r      <= ovf_r || (wr_en && fifo_full_s);
`ifdef UART_TX_PARITY_EN
      par_bit_r  <= par_bit_nx;
`endif
    end
  end

  assign tx       = tx_r;
  assign tf_TXRDY = txrdy_r;
  assign tx_busy  = busy_r;
  assign tx_ovf   = ovf_r;
  assign fifo_cnt = fifo_cnt_s;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected frames are built from the byte value,
// baud divisor and FIFO rules, then compared cycle by cycle against tx.
module tb_uart_tx;

  localparam int OVS   = 16;
  localparam int DEPTH = 4;

  logic       pclk;
  logic       presetn;
  logic [7:0] baud_val;
  logic [7:0] data_in;
  logic       wr_en;
  logic       tx;
  logic       tf_TXRDY;
  logic       tx_busy;
  logic       tx_ovf;
  logic [2:0] fifo_cnt;
`ifdef UART_TX_PARITY_EN
  logic       par_odd_tb;
`endif

  int n_tests;
  int n_fail;

  uart_tx #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .OVS(OVS)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .baud_val(baud_val),
    .data_in (data_in),
    .wr_en   (wr_en),
`ifdef UART_TX_PARITY_EN
    .par_odd (par_odd_tb),
`endif
    .tx      (tx),
    .tf_TXRDY(tf_TXRDY),
    .tx_busy (tx_busy),
    .tx_ovf  (tx_ovf),
    .fifo_cnt(fifo_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle write strobe; returns at the negedge after the write edge.
  task automatic write1(input logic [7:0] b);
    wr_en   = 1'b1;
    data_in = b;
    @(negedge pclk);
    wr_en   = 1'b0;
  endtask

  task automatic idle_check(input int n, input string tag);
    int bad;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      if (tx !== 1'b1) bad++;
      @(negedge pclk);
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // Compare tx against the ideal frame for byte d, starting 'skip' cycles into the start bit.
  task automatic check_frame(input logic [7:0] d, input int baud, input int skip, input string tag);
    logic exp_bits [$];
    int   period;
    period = OVS * (baud + 1);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(((d >> i) & 8'd1) != 8'd0);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back((($countones(d) % 2) == 1) ^ par_odd_tb);
`endif
    exp_bits.push_back(1'b1);
    for (int b = 0; b < exp_bits.size(); b++) begin
      int bad;
      bad = 0;
      for (int c = ((b == 0) ? skip : 0); c < period; c++) begin
        if (tx !== exp_bits[b]) bad++;
        @(negedge pclk);
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(bad), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] b0;
    logic [7:0] r;
    logic       exp_ovf;
    int         bv;

    n_tests  = 0;
    n_fail   = 0;
    presetn  = 1'b1;
    wr_en    = 1'b0;
    data_in  = 8'h00;
    baud_val = 8'd0;
`ifdef UART_TX_PARITY_EN
    par_odd_tb = 1'b0;
`endif

    // Reset state, then 50 idle cycles.
    repeat (3) @(negedge pclk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_txrdy", 32'(tf_TXRDY), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_ovf", 32'(tx_ovf), 32'd0);
    check("rst_cnt", 32'(fifo_cnt), 32'd0);
    presetn = 1'b0;
    idle_check(50, "idle50_tx");
    check("idle_busy", 32'(tx_busy), 32'd0);
    check("idle_cnt", 32'(fifo_cnt), 32'd0);
    check("idle_txrdy", 32'(tf_TXRDY), 32'd1);

    // 0xA5 at the fastest rate: 16-cycle bits.
    baud_val = 8'd0;
    write1(8'hA5);
    check("a5_busy_after_write", 32'(tx_busy), 32'd1);
    @(negedge pclk);
    check_frame(8'hA5, 0, 0, "a5");
    check("a5_busy_end", 32'(tx_busy), 32'd0);

    // Back-to-back frames at baud_val=2 with no idle gap.
    baud_val = 8'd2;
    write1(8'h00);
    write1(8'hFF);
    check_frame(8'h00, 2, 0, "b2b_00");
    check_frame(8'hFF, 2, 0, "b2b_ff");
    check("b2b_busy_end", 32'(tx_busy), 32'd0);

    // Overflow: six writes while the start bit of an earlier frame is on the line.
    baud_val = 8'd0;
    b0 = 8'($urandom);
    write1(b0);
    @(negedge pclk);
    exp_ovf = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom);
      if (q.size() < DEPTH) q.push_back(r);
      else                  exp_ovf = 1'b1;
      write1(r);
    end
    check("ovf_cnt", 32'(fifo_cnt), 32'(q.size()));
    check("ovf_txrdy", 32'(tf_TXRDY), 32'(q.size() < DEPTH));
    check("ovf_flag", 32'(tx_ovf), 32'(exp_ovf));
    check_frame(b0, 0, 6, "ovf_first");
    while (q.size() > 0) begin
      r = q.pop_front();
      check_frame(r, 0, 0, "ovf_q");
    end
    check("ovf_busy_end", 32'(tx_busy), 32'd0);
    idle_check(40, "ovf_no_extra_frame");
    check("ovf_sticky", 32'(tx_ovf), 32'd1);

    // Random bytes and divisors; baud_val changes mid-frame must not disturb the frame.
    for (int k = 0; k < 3; k++) begin
      bv = int'($urandom_range(0, 3));
      baud_val = 8'(bv);
      r = 8'($urandom);
      write1(r);
      @(negedge pclk);
      baud_val = 8'($urandom_range(0, 3));
      check_frame(r, bv, 0, $sformatf("rnd%0d", k));
    end
    check("rnd_busy_end", 32'(tx_busy), 32'd0);

    // Reset during data bit 3 of 0x3C with a second byte still queued.
    baud_val = 8'd0;
    write1(8'h3C);
    write1(8'h81);
    repeat (16 + 3 * 16 + 5) @(negedge pclk);
    check("mid_bit3_tx", 32'(tx), 32'(8'h3C >> 3) & 32'd1);
    check("mid_cnt", 32'(fifo_cnt), 32'd1);
    presetn = 1'b1;
    @(negedge pclk);
    check("mrst_tx", 32'(tx), 32'd1);
    check("mrst_cnt", 32'(fifo_cnt), 32'd0);
    check("mrst_busy", 32'(tx_busy), 32'd0);
    check("mrst_ovf", 32'(tx_ovf), 32'd0);
    check("mrst_txrdy", 32'(tf_TXRDY), 32'd1);
    presetn = 1'b0;
    idle_check(200, "mrst_no_residual");
    check("mrst_busy_after", 32'(tx_busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    baud_val = 8'd0;
    par_odd_tb = 1'b0;
    write1(8'h07);
    @(negedge pclk);
    check_frame(8'h07, 0, 0, "par_even");
    par_odd_tb = 1'b1;
    write1(8'h07);
    @(negedge pclk);
    check_frame(8'h07, 0, 0, "par_odd");
    check("par_busy_end", 32'(tx_busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmit stage directly downstream of the APB UART register slave.
- Consumes the programmed baud divisor `o_baud_val` and the write byte `data_in`, and buffers bytes in a small FIFO.
- Serialises each byte as 8N1, LSB first, onto the `tx` line.
- Returns `tf_TXRDY` (FIFO can accept) to the slave's TXRDY status path.

Parameters:
- DATA_W, 8, byte width; must match the slave's BITWIDTH.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- OVS, 16, baud ticks per bit.

Ports:
- pclk  in  1  clock; all flops update on the rising edge.
- presetn  in  1  synchronous, active-high reset (asserted = 1); name kept from the APB domain.
- baud_val  in  DATA_W  baud divisor, fed from the slave's o_baud_val.
- data_in  in  DATA_W  byte to transmit.
- wr_en  in  1  single-cycle write strobe for data_in.
- tx  out  1  serial line, idle high.
- tf_TXRDY  out  1  FIFO not full.
- tx_busy  out  1  a frame is on the line, or the FIFO is non-empty.
- tx_ovf  out  1  sticky: a write was dropped because the FIFO was full.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: tx=1, tf_TXRDY=1, tx_busy=0, tx_ovf=0, fifo_cnt=0, FSM=IDLE, baud counters=0.
- FIFO write rules:
  - A write is accepted iff wr_en=1 and fifo_cnt<FIFO_DEPTH, evaluated before any same-cycle pop.
  - A write while full is dropped and sets tx_ovf; tx_ovf clears only on reset.
  - A simultaneous accepted write and pop leaves fifo_cnt unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Baud timing:
  - A tick counter counts 0..baud_val, then emits a 1-cycle tick and wraps.
  - A tick_cnt counts OVS ticks per bit, so bit period = OVS*(baud_val+1) pclk cycles (baud_val=0 gives 16 cycles).
  - Both counters clear when leaving IDLE, so every bit is exactly one bit period.
  - baud_val is latched when a byte is popped; changes mid-frame take effect on the next frame.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty: pop, load the shift register, latch baud_val, go to START. A byte written into an empty FIFO at edge N drives tx low after edge N+1.
  - START: tx=0 for one bit period, then DATA.
  - DATA: tx = shift_reg[0]; shift right after each bit. After DATA_W bits go to STOP (or PARITY when enabled).
  - STOP: tx=1 for one bit period. Then go to START directly if the FIFO is non-empty (pop in the same cycle), else IDLE. Back-to-back frames therefore have no idle gap.
- Derived outputs:
  - tf_TXRDY = (fifo_cnt<FIFO_DEPTH), registered from next-state occupancy so it is valid the cycle after the edge that changes it.
  - tx_busy = (state!=IDLE) || (fifo_cnt!=0).
- Reset mid-frame: the frame is aborted, tx returns to 1 the cycle after the reset edge, and the FIFO is flushed.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input par_odd (1 bit) and a PARITY state between DATA and STOP.
  - Parity bit = XOR of data bits, inverted when par_odd=1; held for one bit period.
  - par_odd is latched together with baud_val at pop.
  - Frame is 11 bits.
- Undefined: no par_odd port, no PARITY state, 10-bit frames.

Decomposition:
- Package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
  - OVS_DEFAULT=16 and DATA_W_DEFAULT=8.
  - Frame-length constants.
- Sub-module uart_tx_fifo:
  - Synchronous FIFO with wr_en/rd_en/full/empty/count and pointer wrap.
  - uart_tx instantiates it and contains the baud generator and FSM.

Test Plan:
- Reset then idle 50 cycles -> tx=1, tf_TXRDY=1, tx_busy=0, fifo_cnt=0.
- baud_val=0, write 0xA5 -> tx low after the next edge. Bits are 0,1,0,1,0,0,1,0,1,1, each exactly 16 cycles (160-cycle frame), then tx_busy=0.
- baud_val=2, write 0x00,0xFF back-to-back -> each bit is 48 cycles. Second start bit follows the first stop bit with no gap. Total 960 cycles.
- Write 6 bytes in consecutive cycles while the FSM is mid-frame -> 4 accepted, fifo_cnt=4, tf_TXRDY=0, tx_ovf=1. Exactly 4 frames are sent afterwards.
- Assert presetn in DATA bit 3 of 0x3C -> tx=1 the next cycle, fifo_cnt=0, FSM in IDLE. No residual frame after release.
- UART_TX_PARITY_EN, par_odd=0, write 0x07 -> parity bit=1, 11-bit frame. par_odd=1 -> parity bit=0.
